// File: rtl/exc_commit_ctrl.sv
// exc_commit_ctrl: exception / interrupt / ERET commit controller sitting
// between the write-back stage and CP0. In the commit cycle it drives the
// CP0 update strobes and a pipeline flush combinationally, then offers a
// redirect PC to fetch over a valid/ready handshake.
// Build option: define EXC_COMMIT_INT_EN to enable interrupt detection and
// the interrupt commit path; without it int_req_q is constant 0.
module exc_commit_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hbfc00380,
  parameter logic [4:0]  INT_EXCODE = 5'h00
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ws_valid,
  input  logic [31:0] ws_pc,
  input  logic        ws_bd,
  input  logic        ws_ex,
  input  logic [4:0]  ws_excode,
  input  logic [31:0] ws_badvaddr,
  input  logic        ws_eret,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic [31:0] cp0_epc,
  output logic        wb_ex,
  output logic        wb_bd,
  output logic        wb_eret,
  output logic [4:0]  wb_excode,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_badvaddr,
  output logic        ws_flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
);

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic        int_req_q, int_req_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        take_int_s, take_exc_s, take_eret_s, take_any_s;

  // Only IE/EXL/IM of status and IP of cause matter here.
  logic unused_cp0_s;
  assign unused_cp0_s = ^{cp0_status, cp0_cause};

  // Interrupt pending: enabled, not already in an exception, masked IP hit.
  always_comb begin
`ifdef EXC_COMMIT_INT_EN
    int_req_d = cp0_status[0] & ~cp0_status[1]
              & (|(cp0_status[15:8] & cp0_cause[15:8]));
`else
    int_req_d = 1'b0;
`endif
  end

  // Commit decode: only in IDLE with a valid WB instruction, interrupt first.
  always_comb begin
    take_int_s  = 1'b0;
    take_exc_s  = 1'b0;
    take_eret_s = 1'b0;
    if ((state_q == ST_IDLE) && ws_valid) begin
      if (int_req_q) begin
        take_int_s = 1'b1;
      end else if (ws_ex) begin
        take_exc_s = 1'b1;
      end else if (ws_eret) begin
        take_eret_s = 1'b1;
      end else begin
        take_int_s = 1'b0;
      end
    end else begin
      take_int_s = 1'b0;
    end
    take_any_s = take_int_s | take_exc_s | take_eret_s;
  end

  // CP0 update strobes and data; data is zero whenever no strobe fires.
  always_comb begin
    wb_ex       = 1'b0;
    wb_bd       = 1'b0;
    wb_eret     = 1'b0;
    wb_excode   = 5'h00;
    wb_pc       = 32'h0000_0000;
    wb_badvaddr = 32'h0000_0000;
    if (take_int_s) begin
      wb_ex     = 1'b1;
      wb_excode = INT_EXCODE;
      wb_bd     = ws_bd;
      wb_pc     = ws_pc;
    end else if (take_exc_s) begin
      wb_ex       = 1'b1;
      wb_excode   = ws_excode;
      wb_badvaddr = ws_badvaddr;
      wb_bd       = ws_bd;
      wb_pc       = ws_pc;
    end else if (take_eret_s) begin
      wb_eret = 1'b1;
    end else begin
      wb_ex = 1'b0;
    end
    ws_flush = take_any_s | (state_q == ST_REDIRECT);
  end

  // Next-state logic: latch the redirect target at commit, hold until accepted.
  always_comb begin
    state_d          = state_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (take_any_s) begin
          state_d          = ST_REDIRECT;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = take_eret_s ? cp0_epc : EXC_VECTOR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REDIRECT: begin
        if (redirect_valid_q && redirect_ready) begin
          state_d          = ST_IDLE;
          redirect_valid_d = 1'b0;
        end else begin
          state_d = ST_REDIRECT;
        end
      end
      default: begin
        state_d          = ST_IDLE;
        redirect_valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q          <= ST_IDLE;
      int_req_q        <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'h0000_0000;
    end else begin
      state_q          <= state_d;
      int_req_q        <= int_req_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Bench for exc_commit_ctrl: directed scenarios plus random traffic, all
// compared against a cycle-level behavioural model of the commit rules.
// Honours EXC_COMMIT_INT_EN the same way as the design.
module tb_exc_commit_ctrl;

`ifdef EXC_COMMIT_INT_EN
  localparam bit INT_EN = 1'b1;
`else
  localparam bit INT_EN = 1'b0;
`endif
  localparam logic [31:0] VEC = 32'hbfc00380;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ws_valid, ws_bd, ws_ex, ws_eret;
  logic [31:0] ws_pc, ws_badvaddr;
  logic [4:0]  ws_excode;
  logic [31:0] cp0_status, cp0_cause, cp0_epc;
  logic        wb_ex, wb_bd, wb_eret, ws_flush, redirect_valid, redirect_ready;
  logic [4:0]  wb_excode;
  logic [31:0] wb_pc, wb_badvaddr, redirect_pc;

  exc_commit_ctrl dut (
    .clk(clk), .resetn(resetn),
    .ws_valid(ws_valid), .ws_pc(ws_pc), .ws_bd(ws_bd), .ws_ex(ws_ex),
    .ws_excode(ws_excode), .ws_badvaddr(ws_badvaddr), .ws_eret(ws_eret),
    .cp0_status(cp0_status), .cp0_cause(cp0_cause), .cp0_epc(cp0_epc),
    .wb_ex(wb_ex), .wb_bd(wb_bd), .wb_eret(wb_eret), .wb_excode(wb_excode),
    .wb_pc(wb_pc), .wb_badvaddr(wb_badvaddr), .ws_flush(ws_flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: "busy redirecting?", pending target, delayed interrupt.
  bit          m_redir;
  logic [31:0] m_rpc;
  bit          m_intq;

  // Samples of the last checked cycle, for directed constant checks.
  logic        s_ex, s_eret, s_flush, s_rv;
  logic [4:0]  s_excode;
  logic [31:0] s_bva;
  int          ex_seen;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_in();
    ws_valid = 1'b0; ws_bd = 1'b0; ws_ex = 1'b0; ws_eret = 1'b0;
    ws_pc = 32'h0; ws_badvaddr = 32'h0; ws_excode = 5'h0;
  endtask

  // Called at posedge+1 with inputs already driven; checks at the falling
  // edge, advances the model, and returns at the next posedge+1.
  task automatic cycle();
    logic        e_ex, e_bd, e_eret, e_flush, e_rv;
    logic [4:0]  e_code;
    logic [31:0] e_pc, e_bva, n_rpc;
    bit          n_redir, pend;
    #4;
    e_ex = 0; e_bd = 0; e_eret = 0; e_flush = 0; e_rv = 0;
    e_code = 5'h0; e_pc = 32'h0; e_bva = 32'h0;
    n_redir = m_redir; n_rpc = m_rpc;
    if (!resetn) begin
      n_redir = 0; n_rpc = 32'h0; pend = 0;
    end else begin
      pend = INT_EN && cp0_status[0] && !cp0_status[1]
             && ((cp0_status[15:8] & cp0_cause[15:8]) != 8'h00);
      if (m_redir) begin
        e_flush = 1; e_rv = 1;
        if (redirect_ready) n_redir = 0;
      end else if (ws_valid && (m_intq || ws_ex || ws_eret)) begin
        e_flush = 1; n_redir = 1;
        if (m_intq || ws_ex) begin
          e_ex = 1; e_bd = ws_bd; e_pc = ws_pc; n_rpc = VEC;
          if (m_intq) e_code = 5'h00;
          else begin e_code = ws_excode; e_bva = ws_badvaddr; end
        end else begin
          e_eret = 1; n_rpc = cp0_epc;
        end
      end
    end
    check_val("wb_ex", {31'h0, wb_ex}, {31'h0, e_ex});
    check_val("wb_eret", {31'h0, wb_eret}, {31'h0, e_eret});
    check_val("wb_excode", {27'h0, wb_excode}, {27'h0, e_code});
    check_val("wb_badvaddr", wb_badvaddr, e_bva);
    check_val("ws_flush", {31'h0, ws_flush}, {31'h0, e_flush});
    check_val("redirect_valid", {31'h0, redirect_valid}, {31'h0, e_rv});
    if (e_ex) begin
      check_val("wb_pc", wb_pc, e_pc);
      check_val("wb_bd", {31'h0, wb_bd}, {31'h0, e_bd});
    end
    if (!e_ex && !e_eret) begin
      check_val("wb_pc_zero", wb_pc, 32'h0);
      check_val("wb_bd_zero", {31'h0, wb_bd}, 32'h0);
    end
    if (e_rv) check_val("redirect_pc", redirect_pc, m_rpc);
    s_ex = wb_ex; s_eret = wb_eret; s_flush = ws_flush; s_rv = redirect_valid;
    s_excode = wb_excode; s_bva = wb_badvaddr;
    if (wb_ex === 1'b1) ex_seen++;
    m_redir = n_redir; m_rpc = n_rpc; m_intq = pend;
    @(posedge clk); #1;
  endtask

  initial begin
    resetn = 1'b0; idle_in(); redirect_ready = 1'b0;
    cp0_status = 32'h0; cp0_cause = 32'h0; cp0_epc = 32'h0;
    m_redir = 0; m_rpc = 32'h0; m_intq = 0; ex_seen = 0;
    @(posedge clk); #1;
    cycle(); cycle();
    check_val("rst_rpc", redirect_pc, 32'h0);
    resetn = 1'b1;
    redirect_ready = 1'b1;
    cycle();

    // Syscall exception.
    ws_valid = 1; ws_ex = 1; ws_excode = 5'h08; ws_pc = 32'hbfc01000; ws_bd = 0;
    cycle();
    check_val("sys_ex", {31'h0, s_ex}, 32'h1);
    check_val("sys_code", {27'h0, s_excode}, 32'h8);
    check_val("sys_flush", {31'h0, s_flush}, 32'h1);
    check_val("sys_rv", {31'h0, redirect_valid}, 32'h1);
    check_val("sys_rpc", redirect_pc, 32'hbfc00380);
    idle_in();
    cycle();

    // ERET.
    cp0_epc = 32'hbfc01004; ws_valid = 1; ws_eret = 1;
    cycle();
    check_val("eret_strobe", {31'h0, s_eret}, 32'h1);
    check_val("eret_rpc", redirect_pc, 32'hbfc01004);
    idle_in();
    cycle();

    // Interrupt, then EXL set by "CP0" one cycle after the commit.
    ws_valid = 1; ws_pc = 32'hbfc02000;
    cp0_status = 32'h0040ff01; cp0_cause = 32'h00008000;
    cycle();
    check_val("int_cyc1", {31'h0, s_ex}, 32'h0);
    cycle();
    check_val("int_cyc2", {31'h0, s_ex}, {31'h0, INT_EN});
    cp0_status = 32'h0040ff03;
    ex_seen = 0;
    for (int i = 0; i < 6; i++) cycle();
    check_val("int_exl_none", ex_seen, 32'h0);
    cp0_status = 32'h0; idle_in();
    cycle(); cycle();

    // Backpressure: fetch stalls the redirect for 5 cycles.
    ws_valid = 1; ws_ex = 1; ws_excode = 5'h0c; redirect_ready = 0;
    cycle();
    for (int i = 0; i < 5; i++) begin
      ws_excode = 5'($urandom_range(31, 0));
      cycle();
      check_val("bp_rv", {31'h0, s_rv}, 32'h1);
      check_val("bp_flush", {31'h0, s_flush}, 32'h1);
      check_val("bp_ignored", {31'h0, s_ex}, 32'h0);
    end
    idle_in(); redirect_ready = 1;
    cycle();
    cycle();
    check_val("bp_idle", {31'h0, s_rv}, 32'h0);

    // Priority: interrupt beats instruction exception and ERET.
    cp0_status = 32'h0040ff01; cp0_cause = 32'h00008000;
    cycle();
    ws_valid = 1; ws_ex = 1; ws_excode = 5'h04; ws_badvaddr = 32'h1; ws_eret = 1;
    cycle();
    check_val("prio_code", {27'h0, s_excode}, INT_EN ? 32'h0 : 32'h4);
    check_val("prio_bva", s_bva, INT_EN ? 32'h0 : 32'h1);
    check_val("prio_eret", {31'h0, s_eret}, 32'h0);
    cp0_status = 32'h0; idle_in();
    cycle(); cycle();

    // Reset while in REDIRECT.
    ws_valid = 1; ws_ex = 1; ws_excode = 5'h0a; redirect_ready = 0;
    cycle();
    idle_in();
    cycle();
    resetn = 0;
    #1;
    check_val("rst_mid_rv", {31'h0, redirect_valid}, 32'h0);
    m_redir = 0; m_rpc = 32'h0; m_intq = 0;
    @(posedge clk); #1;
    cycle();
    resetn = 1;
    cycle();
    check_val("rst_idle", {31'h0, s_rv}, 32'h0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      ws_valid    = ($urandom_range(99, 0) < 70);
      ws_ex       = ($urandom_range(99, 0) < 20);
      ws_eret     = ($urandom_range(99, 0) < 15);
      ws_bd       = 1'($urandom);
      ws_pc       = $urandom;
      ws_excode   = 5'($urandom);
      ws_badvaddr = $urandom;
      cp0_epc     = $urandom;
      redirect_ready = ($urandom_range(99, 0) < 60);
      if ($urandom_range(9, 0) == 0) begin
        cp0_status = {16'h0, 8'($urandom), 6'h0, 1'($urandom), 1'($urandom)};
        cp0_cause  = {16'h0, 8'($urandom_range(3, 0) == 0 ? $urandom : 0), 8'h0};
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
